image_write: RTL and testbench
==============================

// Module: image_write
// PURPOSE
//  Write-side counterpart of image_read: accepts a layer's result pixel stream and stores it in image memory.
//  Memory layout is the one image_read fetches: width fastest, then height, then depth groups.
//  Sits downstream of the conv/pool datapath and upstream of the image memory write port.
//  A config bus sets the frame geometry and base address; a `next` pulse arms one frame.
// PARAMETERS
//  CFG_DWIDTH    32    config data width
//  CFG_AWIDTH    5     config address width
//  GROUP_NB      4     channels packed per memory word; power of two
//  IMG_WIDTH     16    bits per pixel
//  MEM_AWIDTH    16    memory address width
//  CFG_IW_IMG_W  5'd8  cfg addr: data[15:0] = width-1
//  CFG_IW_IMG_DH 5'd9  cfg addr: data[31:16] = depth-1 (channels), data[15:0] = height-1
//  CFG_IW_BASE   5'd10 cfg addr: data[MEM_AWIDTH-1:0] = frame base address
// PORTS
//  clk        in   1                   clock; all logic on posedge
//  rst        in   1                   reset; synchronous, active-high
//  cfg_data   in   CFG_DWIDTH          config write data
//  cfg_addr   in   CFG_AWIDTH          config write address
//  cfg_valid  in   1                   config write strobe
//  next       in   1                   one-cycle pulse: arm writing of one frame
//  res_bus    in   GROUP_NB*IMG_WIDTH  result word: GROUP_NB channels of one pixel
//  res_last   in   1                   producer marks the final word of the frame
//  res_val    in   1                   result word valid
//  res_rdy    out  1                   block accepts a result word
//  wr_val     out  1                   memory write strobe
//  wr_addr    out  MEM_AWIDTH          memory write address
//  wr_data    out  GROUP_NB*IMG_WIDTH  memory write data
//  done       out  1                   one-cycle pulse: last word of the frame written
//  err        out  1                   sticky: res_last disagreed with the geometry
// BEHAVIOUR
//  Reset
//   - Outputs: res_rdy=0, wr_val=0, wr_addr=0, wr_data=0, done=0, err=0.
//   - State=IDLE; config registers=0; counters=0.
//  Config
//   - A write lands only when cfg_valid=1, cfg_addr matches a CFG_IW_* address, and state=IDLE.
//   - Writes in ACTIVE are ignored; unknown addresses are ignored.
//  Geometry
//   - Columns = img_w+1; rows = img_h+1.
//   - Groups = (img_d >> log2(GROUP_NB)) + 1.
//   - Counters w_cnt, h_cnt, g_cnt each run 0..max.
//  FSM
//   - IDLE->ACTIVE on next=1: counters cleared, addr ptr=base, err cleared.
//   - ACTIVE->IDLE on the beat accepted with w,h,g all at max.
//   - next while ACTIVE is ignored.
//  Handshake
//   - res_rdy = (state==ACTIVE), registered; it is 0 in the cycle after the final beat.
//   - A beat transfers when res_val && res_rdy.
//  Write path, latency 1
//   - The cycle after a transfer: wr_val=1, wr_addr=ptr, wr_data=res_bus. Otherwise wr_val=0.
//   - wr_addr and wr_data hold their last value while wr_val=0.
//   - ptr increments by 1 per transfer, modulo 2^MEM_AWIDTH (wraps silently).
//  Counters
//   - w_cnt increments per transfer.
//   - At w max: w_cnt clears and h_cnt increments.
//   - At h max (with w max): h_cnt clears and g_cnt increments.
//  done
//   - Asserted in the same cycle as the final wr_val.
//  err
//   - Set if res_last=1 on a non-final transfer, or res_last=0 on the final transfer.
//   - The frame continues counting regardless; err holds until the next `next` or rst.
//  Reset mid-frame
//   - Immediate return to IDLE. A pending write is dropped (wr_val=0 next cycle); no done pulse.
// TESTING
//  1. W=9, H=4, D=7 (2 groups), base=0x0100, res_val held 1
//     -> 100 writes, addr 0x0100..0x0163, done with the 100th write, err=0.
//  2. Same frame, res_val toggling pseudo-randomly
//     -> identical addr/data sequence; no beat lost or duplicated.
//  3. res_last asserted on beat 50 and not on beat 100
//     -> err=1 from beat 50; writes continue; done on beat 100.
//  4. base=0xFFF0, W=31, H=0, D=3 -> 32 writes, addr 0xFFF0..0xFFFF then 0x0000..0x000F.
//  5. rst at beat 20, then next
//     -> res_rdy=0 and wr_val=0 after rst; the new frame restarts at base.
//  6. next and a CFG_IW_BASE write while ACTIVE -> both ignored; the frame completes unchanged.

Source files
------------

// File: rtl/image_write.sv
// ----------------------------------------------------------------------------
// image_write
//   Stores a layer's result pixel stream into image memory using the layout
//   that image_read fetches: width fastest, then height, then depth groups.
//   The config bus programs the frame geometry and the base address while the
//   block is idle. A `next` pulse arms one frame.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   cfg_data/addr/valid   config register write port
//   next                  one-cycle pulse that arms one frame
//   res_bus/last/val      result stream in (GROUP_NB channels per word)
//   res_rdy               result stream ready (high while a frame is active)
//   wr_val/addr/data      memory write port, one cycle after each accepted beat
//   done                  pulses with the final memory write of the frame
//   err                   sticky: res_last disagreed with the programmed geometry
// ----------------------------------------------------------------------------
module image_write #(
    parameter int unsigned CFG_DWIDTH    = 32,
    parameter int unsigned CFG_AWIDTH    = 5,
    parameter int unsigned GROUP_NB      = 4,
    parameter int unsigned IMG_WIDTH     = 16,
    parameter int unsigned MEM_AWIDTH    = 16,
    parameter logic [4:0]  CFG_IW_IMG_W  = 5'd8,
    parameter logic [4:0]  CFG_IW_IMG_DH = 5'd9,
    parameter logic [4:0]  CFG_IW_BASE   = 5'd10
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CFG_DWIDTH-1:0]           cfg_data,
    input  logic [CFG_AWIDTH-1:0]           cfg_addr,
    input  logic                            cfg_valid,
    input  logic                            next,
    input  logic [GROUP_NB*IMG_WIDTH-1:0]   res_bus,
    input  logic                            res_last,
    input  logic                            res_val,
    output logic                            res_rdy,
    output logic                            wr_val,
    output logic [MEM_AWIDTH-1:0]           wr_addr,
    output logic [GROUP_NB*IMG_WIDTH-1:0]   wr_data,
    output logic                            done,
    output logic                            err
);

    localparam int unsigned LOG2G = $clog2(GROUP_NB);
    localparam int unsigned DW    = GROUP_NB * IMG_WIDTH;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    logic [0:0]            r_state;
    logic [15:0]           r_img_w;
    logic [15:0]           r_img_h;
    logic [15:0]           r_img_d;
    logic [MEM_AWIDTH-1:0] r_base;
    logic [MEM_AWIDTH-1:0] r_ptr;
    logic [15:0]           r_w_cnt;
    logic [15:0]           r_h_cnt;
    logic [15:0]           r_g_cnt;
    logic                  r_wr_val;
    logic [MEM_AWIDTH-1:0] r_wr_addr;
    logic [DW-1:0]         r_wr_data;
    logic                  r_done;
    logic                  r_err;

    logic                  w_xfer;
    logic                  w_w_max;
    logic                  w_h_max;
    logic                  w_g_max;
    logic                  w_final;
    logic [15:0]           w_g_last;

    // Depth is programmed in channels; GROUP_NB channels share one word.
    assign w_g_last = r_img_d >> LOG2G;

    assign w_xfer  = res_val && (r_state == S_ACTIVE);
    assign w_w_max = (r_w_cnt == r_img_w);
    assign w_h_max = (r_h_cnt == r_img_h);
    assign w_g_max = (r_g_cnt == w_g_last);
    assign w_final = w_xfer && w_w_max && w_h_max && w_g_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_img_w   <= '0;
            r_img_h   <= '0;
            r_img_d   <= '0;
            r_base    <= '0;
            r_ptr     <= '0;
            r_w_cnt   <= '0;
            r_h_cnt   <= '0;
            r_g_cnt   <= '0;
            r_wr_val  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_wr_val <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        case (cfg_addr)
                            CFG_IW_IMG_W:  r_img_w <= cfg_data[15:0];
                            CFG_IW_IMG_DH: begin
                                r_img_h <= cfg_data[15:0];
                                r_img_d <= cfg_data[31:16];
                            end
                            CFG_IW_BASE:   r_base <= cfg_data[MEM_AWIDTH-1:0];
                            default: ;
                        endcase
                    end
                    if (next) begin
                        r_state <= S_ACTIVE;
                        r_w_cnt <= '0;
                        r_h_cnt <= '0;
                        r_g_cnt <= '0;
                        r_ptr   <= r_base;
                        r_err   <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    if (w_xfer) begin
                        r_wr_val  <= 1'b1;
                        r_wr_addr <= r_ptr;
                        r_wr_data <= res_bus;
                        r_ptr     <= r_ptr + 1'b1;
                        r_done    <= w_final;
                        // Producer's frame marker must line up with the geometry.
                        if (res_last != w_final)
                            r_err <= 1'b1;
                        if (w_w_max) begin
                            r_w_cnt <= '0;
                            if (w_h_max) begin
                                r_h_cnt <= '0;
                                r_g_cnt <= r_g_cnt + 1'b1;
                            end else begin
                                r_h_cnt <= r_h_cnt + 1'b1;
                            end
                        end else begin
                            r_w_cnt <= r_w_cnt + 1'b1;
                        end
                        if (w_final)
                            r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign res_rdy = (r_state == S_ACTIVE);
    assign wr_val  = r_wr_val;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign done    = r_done;
    assign err     = r_err;

endmodule

// File: tb/tb_image_write.sv
// ----------------------------------------------------------------------------
// tb_image_write
//   Randomized stimulus for image_write against a beat-count reference model:
//   the k-th accepted beat of a frame must be written to base+k, the frame is
//   (W+1)*(H+1)*(D/4+1) beats long, and res_last must mark exactly the final one.
// ----------------------------------------------------------------------------
module tb_image_write;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_data;
    logic [4:0]  cfg_addr;
    logic        cfg_valid;
    logic        next;
    logic [63:0] res_bus;
    logic        res_last;
    logic        res_val;
    logic        res_rdy;
    logic        wr_val;
    logic [15:0] wr_addr;
    logic [63:0] wr_data;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    image_write #(
        .CFG_DWIDTH (32),
        .CFG_AWIDTH (5),
        .GROUP_NB   (4),
        .IMG_WIDTH  (16),
        .MEM_AWIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_data  (cfg_data),
        .cfg_addr  (cfg_addr),
        .cfg_valid (cfg_valid),
        .next      (next),
        .res_bus   (res_bus),
        .res_last  (res_last),
        .res_val   (res_val),
        .res_rdy   (res_rdy),
        .wr_val    (wr_val),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .done      (done),
        .err       (err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [15:0] m_w, m_h, m_d, m_base, m_fbase;
    int          m_total;
    int          m_n;
    bit          m_active;
    bit          m_err;
    bit          e_wv, e_done;
    logic [15:0] e_addr;
    logic [63:0] e_data;
    int          obs_writes;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (beat %0d, t=%0t)", tag, obs, exp, m_n, $time);
        end
    endtask

    // Advance one clock, update the model with the inputs seen at that edge,
    // then compare every output.
    task automatic step();
        bit was_active;
        bit is_last;
        @(posedge clk);
        #1;
        was_active = m_active;
        e_wv   = 1'b0;
        e_done = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_err    = 1'b0;
            m_w = '0; m_h = '0; m_d = '0; m_base = '0;
            e_addr = '0;
            e_data = '0;
        end else begin
            if (was_active && res_val) begin
                is_last = (m_n == m_total - 1);
                e_wv    = 1'b1;
                e_addr  = m_fbase + 16'(m_n);
                e_data  = res_bus;
                e_done  = is_last;
                if (res_last != is_last) m_err = 1'b1;
                m_n++;
                if (is_last) m_active = 1'b0;
            end else if (!was_active && next) begin
                m_active = 1'b1;
                m_n      = 0;
                m_err    = 1'b0;
                m_fbase  = m_base;
                m_total  = (int'(m_w) + 1) * (int'(m_h) + 1) * (int'(m_d) / 4 + 1);
            end
            if (!was_active && cfg_valid) begin
                case (cfg_addr)
                    5'd8:  m_w = cfg_data[15:0];
                    5'd9:  begin m_h = cfg_data[15:0]; m_d = cfg_data[31:16]; end
                    5'd10: m_base = cfg_data[15:0];
                    default: ;
                endcase
            end
        end
        if (wr_val === 1'b1) obs_writes++;
        check("res_rdy", res_rdy, m_active);
        check("wr_val",  wr_val,  e_wv);
        check("done",    done,    e_done);
        check("err",     err,     m_err);
        check("wr_addr", wr_addr, e_addr);
        check("wr_data", wr_data, e_data);
    endtask

    task automatic cfg(input logic [4:0] a, input logic [31:0] d);
        cfg_addr  = a;
        cfg_data  = d;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic geom(input int w, input int h, input int d, input int base);
        cfg(5'd8,  32'(w));
        cfg(5'd9,  {16'(d), 16'(h)});
        cfg(5'd10, 32'(base));
    endtask

    // pct: res_val probability; last_at: beat number (1-based) carrying
    // res_last, or -1 for the correct final beat; inj: poke next and a base
    // write mid-frame; rst_at: assert rst once this many beats are accepted.
    task automatic run(input int pct, input int last_at, input bit inj,
                       input int rst_at, input int exp_writes);
        obs_writes = 0;
        next = 1'b1;
        step();
        next = 1'b0;
        for (int c = 0; c < 4000 && m_active; c++) begin
            if (rst_at >= 0 && m_n == rst_at) begin
                rst     = 1'b1;
                res_val = 1'b1;
                res_bus = {$urandom, $urandom};
                step();
                rst     = 1'b0;
                res_val = 1'b0;
                break;
            end
            res_val  = ($urandom_range(99) < pct);
            res_bus  = {$urandom, $urandom};
            res_last = (last_at >= 0) ? (m_n == last_at - 1) : (m_n == m_total - 1);
            if (inj && m_n == 10) begin
                next      = 1'b1;
                cfg_valid = 1'b1;
                cfg_addr  = 5'd10;
                cfg_data  = 32'h0000_5555;
            end
            step();
            next      = 1'b0;
            cfg_valid = 1'b0;
            res_val   = 1'b0;
            res_last  = 1'b0;
        end
        check("frame_end", m_active, 1'b0);
        step();
        step();
        check("writes", obs_writes, exp_writes);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cfg_data = '0; cfg_addr = '0; cfg_valid = 1'b0; next = 1'b0;
        res_bus = '0; res_last = 1'b0; res_val = 1'b0;
        m_w = '0; m_h = '0; m_d = '0; m_base = '0; m_fbase = '0;
        m_total = 0; m_n = 0; m_active = 1'b0; m_err = 1'b0;
        e_wv = 1'b0; e_done = 1'b0; e_addr = '0; e_data = '0; obs_writes = 0;

        step();
        step();
        rst = 1'b0;
        step();

        // Unknown address must not disturb anything.
        cfg(5'd3, 32'hFFFF_FFFF);
        geom(9, 4, 7, 16'h0100);

        run(100, -1, 1'b0, -1, 100);   // continuous stream
        run(50,  -1, 1'b0, -1, 100);   // bursty stream
        run(70,  50, 1'b0, -1, 100);   // misplaced res_last
        run(80,  -1, 1'b1, -1, 100);   // next + base write while active
        run(100, -1, 1'b0, -1, 100);   // base must still be 0x0100

        geom(31, 0, 3, 16'hFFF0);      // address wrap
        run(60,  -1, 1'b0, -1, 32);

        geom(9, 4, 7, 16'h0100);
        run(100, -1, 1'b0, 20, 20);    // reset mid-frame
        step();
        step();
        geom(9, 4, 7, 16'h0100);
        run(90,  -1, 1'b0, -1, 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
